alu32_bist: RTL and testbench
=============================

# alu32_bist

Built-in self-test controller for the 32-bit gate-level ALU. It generates pseudo-random operand pairs and a carry-in, and for each pair sweeps all eight ALU operation codes. It compacts every result and carry-out into a 32-bit MISR signature and compares the final signature against a golden value. It sits on both sides of the ALU: its operand outputs drive the ALU inputs, and it consumes the ALU's result and carry outputs.

## Interface
Parameters:
- VECTORS, 1000: number of operand pairs per run (1..65535).
- SEED1, 32'h00000001: In1 LFSR seed; a zero value is replaced by 32'h1.
- SEED2, 32'h0000ACE1: In2 LFSR seed; a zero value is replaced by 32'h1.
- GOLDEN_SIG, 32'h00000000: expected final signature.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  run request, sampled on clk.
- In1  out  32  operand 1 to the ALU (In1 LFSR register).
- In2  out  32  operand 2 to the ALU (In2 LFSR register).
- CI  out  1  carry-in to the ALU, equal to In1[0] ^ In2[31] (combinational from registers).
- A  out  3  ALU operation select (registered counter).
- FinalOut  in  32  ALU result, combinational from In1/In2/CI/A.
- CO  in  1  ALU carry-out.
- Busy  out  1  high while in RUN.
- Done  out  1  high in DONE.
- Pass  out  1  registered Signature == GOLDEN_SIG; valid while Done=1.
- Signature  out  32  MISR register.
- VecCount  out  16  count of completed operand pairs.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Transitions:
  - IDLE → RUN on Start=1.
  - DONE → RUN on Start=1 (restart).
  - RUN → DONE after the capture at A=7 when VecCount reaches VECTORS-1.
  - Start is ignored in RUN.
- On entering RUN:
  - In1 loads SEED1 (zero-fixed), In2 loads SEED2 (zero-fixed).
  - A, Signature and VecCount load 0.
  - Done and Pass clear.
- Each RUN cycle:
  - Capture into the MISR: Signature ← {Signature[30:0], fb(Signature)} ^ FinalOut ^ {CO, 31'b0}.
  - A increments and wraps 7 → 0.
  - When A=7 at capture: In1 and In2 each step their LFSR, and VecCount increments.
- LFSR/MISR feedback: fb(x) = x[31]^x[21]^x[1]^x[0]. LFSR step: x ← {x[30:0], fb(x)}.
- DONE: all registers hold. Pass = (Signature == GOLDEN_SIG), registered on the RUN→DONE edge.
- The ALU is combinational, so FinalOut and CO for the current In1/In2/CI/A are captured at the same edge. There is no pipeline slot.

## Timing
- Reset values (asynchronous, immediate):
  - In1 = SEED1 (zero-fixed), In2 = SEED2 (zero-fixed).
  - A = 0, Signature = 0, VecCount = 0.
  - Busy = 0, Done = 0, Pass = 0.
  - CI follows its combinational definition.
- Start sampled at edge N: Busy=1 and A=0 from N+1.
- The first capture occurs at edge N+2.
- A run has exactly 8·VECTORS capture edges.
- The last capture edge also asserts Done and Pass and deasserts Busy.
- Done stays high until the next Start or reset.
- Reset mid-RUN aborts the run immediately and returns the block to IDLE with all reset values. No partial Done is produced.
- VecCount at Done equals VECTORS (the final increment occurs on the last edge).

## Test plan
- Reset: hold rst_n=0, then release. Required: In1=1, In2=32'hACE1, CI = 1^0 = 1, A=0, Busy=Done=Pass=0, Signature=0.
- A sweep and LFSR step (SEED1=1): Start pulse, then observe 9 cycles.
  - A steps 0,1,…,7,0.
  - In1 changes 1→3 after the 8th capture and 3→6 after the 16th.
  - VecCount 0→1→2.
- MISR with a stub ALU (FinalOut=32'h1, CO=0), VECTORS=1: Signature after 8 captures = 32'h00000092. Required: Done=1, Busy=0, VecCount=1, Pass=1 with GOLDEN_SIG=32'h92.
- Golden mismatch: same stimulus with GOLDEN_SIG=0. Required: Done=1, Pass=0.
- Start during RUN: pulse Start at the 4th RUN cycle. Required: no restart (A continues at 4, Signature is not cleared), and the run length is unchanged.
- Asynchronous reset mid-run: drop rst_n at capture 5 between clock edges. Required: all outputs return to reset values immediately. A subsequent Start reproduces the full-run signature bit-exactly against a real ALU with VECTORS=1000.

Source files
------------

// File: rtl/alu32_bist.sv
// -----------------------------------------------------------------------------
// alu32_bist
//
// Built-in self-test controller for the 32-bit combinational ALU. Two 32-bit
// LFSRs supply operand pairs; for each pair the controller sweeps all eight
// operation codes. Every ALU result and carry-out is folded into a 32-bit MISR.
// At the end of the run, the final signature is compared against a golden
// value.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   Start      in   1   run request (registered, ignored while running)
//   In1        out  32  operand 1 to the ALU (LFSR register)
//   In2        out  32  operand 2 to the ALU (LFSR register)
//   CI         out  1   carry-in to the ALU, In1[0] ^ In2[31]
//   A          out  3   ALU operation select
//   FinalOut   in   32  ALU result (combinational from In1/In2/CI/A)
//   CO         in   1   ALU carry-out
//   Busy       out  1   run in progress
//   Done       out  1   run complete; held until the next Start or reset
//   Pass       out  1   final signature matched GOLDEN_SIG (valid with Done)
//   Signature  out  32  MISR register
//   VecCount   out  16  completed operand pairs
// -----------------------------------------------------------------------------
module alu32_bist #(
  parameter int unsigned VECTORS    = 1000,
  parameter logic [31:0] SEED1      = 32'h0000_0001,
  parameter logic [31:0] SEED2      = 32'h0000_ACE1,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  output logic [31:0] In1,
  output logic [31:0] In2,
  output logic        CI,
  output logic [2:0]  A,
  input  logic [31:0] FinalOut,
  input  logic        CO,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [31:0] Signature,
  output logic [15:0] VecCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // An all-zero LFSR state is a lock-up state, so a zero seed is replaced.
  localparam logic [31:0] SEED1_FIX = (SEED1 == 32'h0) ? 32'h1 : SEED1;
  localparam logic [31:0] SEED2_FIX = (SEED2 == 32'h0) ? 32'h1 : SEED2;
  localparam logic [15:0] LAST_VEC  = 16'(VECTORS - 1);

  // Feedback taps shared by both LFSRs and the MISR.
  function automatic logic fb(input logic [31:0] x);
    return x[31] ^ x[21] ^ x[1] ^ x[0];
  endfunction

  state_t      state_q, state_d;
  logic        start_q;
  logic        load;
  logic        capture;
  logic        finish;
  logic        pair_end;
  logic [31:0] sig_next;

  assign CI       = In1[0] ^ In2[31];
  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign pair_end = (A == 3'd7);

  // The ALU is combinational. The result for the current In1/In2/CI/A is
  // therefore folded in at the same edge that advances the operands.
  assign sig_next = {Signature[30:0], fb(Signature)} ^ FinalOut ^ {CO, 31'b0};

  // Next-state and control decode.
  // NOTE: every signal driven here gets a default first. A path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_q) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        capture = 1'b1;
        if (pair_end && (VecCount == LAST_VEC)) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments. Every register
  // then samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Start is sampled one edge ahead of the load. While running it is
      // masked, so a pulse during RUN cannot trigger a restart from DONE.
      start_q <= Start && (state_q != RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      In1       <= SEED1_FIX;
      In2       <= SEED2_FIX;
      A         <= 3'd0;
      Signature <= 32'h0;
      VecCount  <= 16'd0;
      Pass      <= 1'b0;
    end else if (load) begin
      In1       <= SEED1_FIX;
      In2       <= SEED2_FIX;
      A         <= 3'd0;
      Signature <= 32'h0;
      VecCount  <= 16'd0;
      Pass      <= 1'b0;
    end else if (capture) begin
      Signature <= sig_next;
      A         <= A + 3'd1;
      if (pair_end) begin
        In1      <= {In1[30:0], fb(In1)};
        In2      <= {In2[30:0], fb(In2)};
        VecCount <= VecCount + 16'd1;
      end
      // Compare the signature that the final capture produces, not the stale one.
      if (finish) begin
        Pass <= (sig_next == GOLDEN_SIG);
      end
    end
  end

endmodule

// File: tb/tb_alu32_bist.sv
// -----------------------------------------------------------------------------
// tb_alu32_bist
//
// Directed bench for alu32_bist. It uses three instances:
//   u_main  - VECTORS=1000, default seeds, driven by a behavioural ALU
//   u_pass  - VECTORS=1, stub ALU (FinalOut=1, CO=0), GOLDEN_SIG=32'h92
//   u_fail  - VECTORS=1, the same stub, GOLDEN_SIG=0
// -----------------------------------------------------------------------------
module tb_alu32_bist;

  logic clk;
  logic rst_n;
  logic start_m;
  logic start_s;

  int n_checks = 0;
  int n_fail   = 0;

  // u_main signals
  logic [31:0] in1_m, in2_m, fo_m, sig_m;
  logic        ci_m, co_m, busy_m, done_m, pass_m;
  logic [2:0]  a_m;
  logic [15:0] vc_m;

  // u_pass signals
  logic [31:0] in1_p, in2_p, sig_p;
  logic        ci_p, busy_p, done_p, pass_p;
  logic [2:0]  a_p;
  logic [15:0] vc_p;

  // u_fail signals
  logic [31:0] in1_f, in2_f, sig_f;
  logic        ci_f, busy_f, done_f, pass_f;
  logic [2:0]  a_f;
  logic [15:0] vc_f;

  logic [31:0] exp_sig;

  // Behavioural 32-bit ALU: returns {carry, result}.
  function automatic logic [32:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, x} + {1'b0, y} + 33'(ci);
      3'd1:    return {1'b0, x} + {1'b0, ~y} + 33'(ci);
      3'd2:    return {1'b0, x & y};
      3'd3:    return {1'b0, x | y};
      3'd4:    return {1'b0, x ^ y};
      3'd5:    return {1'b0, ~(x | y)};
      3'd6:    return {x, ci};
      default: return {x[0], ci, x[31:1]};
    endcase
  endfunction

  function automatic logic tap(input logic [31:0] x);
    return x[31] ^ x[21] ^ x[1] ^ x[0];
  endfunction

  // Reference signature for the full VECTORS=1000 run against alu_model.
  function automatic logic [31:0] ref_signature();
    logic [31:0] r1, r2, s;
    logic [32:0] o;
    logic        c;
    r1 = 32'h1;
    r2 = 32'hACE1;
    s  = 32'h0;
    for (int v = 0; v < 1000; v++) begin
      for (int op = 0; op < 8; op++) begin
        c = r1[0] ^ r2[31];
        o = alu_model(r1, r2, c, 3'(op));
        s = {s[30:0], tap(s)} ^ o[31:0] ^ {o[32], 31'b0};
      end
      r1 = {r1[30:0], tap(r1)};
      r2 = {r2[30:0], tap(r2)};
    end
    return s;
  endfunction

  assign {co_m, fo_m} = alu_model(in1_m, in2_m, ci_m, a_m);

  alu32_bist #(.VECTORS(1000)) u_main (
    .clk(clk), .rst_n(rst_n), .Start(start_m),
    .In1(in1_m), .In2(in2_m), .CI(ci_m), .A(a_m),
    .FinalOut(fo_m), .CO(co_m),
    .Busy(busy_m), .Done(done_m), .Pass(pass_m),
    .Signature(sig_m), .VecCount(vc_m)
  );

  alu32_bist #(.VECTORS(1), .GOLDEN_SIG(32'h0000_0092)) u_pass (
    .clk(clk), .rst_n(rst_n), .Start(start_s),
    .In1(in1_p), .In2(in2_p), .CI(ci_p), .A(a_p),
    .FinalOut(32'h0000_0001), .CO(1'b0),
    .Busy(busy_p), .Done(done_p), .Pass(pass_p),
    .Signature(sig_p), .VecCount(vc_p)
  );

  alu32_bist #(.VECTORS(1), .GOLDEN_SIG(32'h0000_0000)) u_fail (
    .clk(clk), .rst_n(rst_n), .Start(start_s),
    .In1(in1_f), .In2(in2_f), .CI(ci_f), .A(a_f),
    .FinalOut(32'h0000_0001), .CO(1'b0),
    .Busy(busy_f), .Done(done_f), .Pass(pass_f),
    .Signature(sig_f), .VecCount(vc_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main_reset(input string tag);
    check({tag, "_in1"},  in1_m,  32'h0000_0001);
    check({tag, "_in2"},  in2_m,  32'h0000_ACE1);
    check({tag, "_ci"},   32'(ci_m),   32'h1);
    check({tag, "_a"},    32'(a_m),    32'h0);
    check({tag, "_busy"}, 32'(busy_m), 32'h0);
    check({tag, "_done"}, 32'(done_m), 32'h0);
    check({tag, "_pass"}, 32'(pass_m), 32'h0);
    check({tag, "_sig"},  sig_m,  32'h0);
    check({tag, "_vc"},   32'(vc_m),   32'h0);
  endtask

  task automatic run_main_to_done(input string tag, input int expect_cycles);
    int n;
    n = 0;
    while (!done_m && n < 9000) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(done_m), 32'h1);
    check({tag, "_len"},     32'(n),      32'(expect_cycles));
    check({tag, "_busy"},    32'(busy_m), 32'h0);
    check({tag, "_vc"},      32'(vc_m),   32'd1000);
    check({tag, "_a"},       32'(a_m),    32'h0);
    check({tag, "_sig"},     sig_m,       exp_sig);
    check({tag, "_pass"},    32'(pass_m), 32'(exp_sig == 32'h0));
  endtask

  initial begin
    exp_sig = ref_signature();
    rst_n   = 1'b0;
    start_m = 1'b0;
    start_s = 1'b0;

    // Reset state while rst_n is still low, then again after release.
    #12;
    check_main_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    check_main_reset("rst_rel");

    // A sweep and LFSR stepping on u_main.
    start_m = 1'b1;
    tick();                       // edge N samples Start
    start_m = 1'b0;
    check("sweep_busy_n", 32'(busy_m), 32'h0);
    tick();                       // edge N+1 enters RUN
    check("sweep_busy_n1", 32'(busy_m), 32'h1);
    check("sweep_a_n1",    32'(a_m),    32'h0);
    check("sweep_in1_n1",  in1_m,       32'h1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("sweep_a_%0d", k), 32'(a_m), 32'(k % 8));
      if (k == 7)  check("sweep_in1_7",  in1_m, 32'h1);
      if (k == 8)  check("sweep_in1_8",  in1_m, 32'h3);
      if (k == 8)  check("sweep_in2_8",  in2_m, 32'h0001_59C3);
      if (k == 8)  check("sweep_vc_8",   32'(vc_m), 32'h1);
      if (k == 15) check("sweep_in1_15", in1_m, 32'h3);
      if (k == 16) check("sweep_in1_16", in1_m, 32'h6);
      if (k == 16) check("sweep_vc_16",  32'(vc_m), 32'h2);
    end
    run_main_to_done("full", 8000 - 16);

    // Stub ALU, single vector: golden match and golden mismatch.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    check("stub_busy", 32'(busy_p), 32'h1);
    for (int k = 1; k <= 7; k++) tick();
    check("stub_done_7", 32'(done_p), 32'h0);
    tick();
    check("stub_sig",     sig_p,       32'h0000_0092);
    check("stub_done",    32'(done_p), 32'h1);
    check("stub_busy_end", 32'(busy_p), 32'h0);
    check("stub_vc",      32'(vc_p),   32'h1);
    check("stub_pass",    32'(pass_p), 32'h1);
    check("stubf_done",   32'(done_f), 32'h1);
    check("stubf_sig",    sig_f,       32'h0000_0092);
    check("stubf_pass",   32'(pass_f), 32'h0);

    // Restart from DONE, with Start pulsed during RUN.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    check("rs_done_clr", 32'(done_p), 32'h0);
    check("rs_pass_clr", 32'(pass_p), 32'h0);
    check("rs_sig_clr",  sig_p,       32'h0);
    for (int k = 1; k <= 3; k++) tick();
    start_s = 1'b1;
    tick();                       // capture 4 with Start high
    start_s = 1'b0;
    check("rs_a_4",   32'(a_p), 32'h4);
    check("rs_sig_4", sig_p,    32'h0000_0009);
    tick();
    check("rs_a_5",   32'(a_p), 32'h5);
    check("rs_sig_5", sig_p,    32'h0000_0012);
    tick();
    tick();
    check("rs_done_7", 32'(done_p), 32'h0);
    tick();
    check("rs_done_8", 32'(done_p), 32'h1);
    check("rs_sig_8",  sig_p,       32'h0000_0092);
    check("rs_pass_8", 32'(pass_p), 32'h1);
    tick();
    tick();
    check("rs_hold_done", 32'(done_p), 32'h1);
    check("rs_hold_sig",  sig_p,       32'h0000_0092);
    check("rs_hold_a",    32'(a_p),    32'h0);

    // Asynchronous reset mid-run on u_main, then a clean full rerun.
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    tick();
    check("ar_done_clr", 32'(done_m), 32'h0);
    for (int k = 1; k <= 5; k++) tick();
    check("ar_a_5", 32'(a_m), 32'h5);
    #3;
    rst_n = 1'b0;
    #1;
    check_main_reset("ar_async");
    #2;
    rst_n = 1'b1;
    tick();
    check("ar_idle_busy", 32'(busy_m), 32'h0);
    check("ar_idle_done", 32'(done_m), 32'h0);
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    tick();
    run_main_to_done("rerun", 8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
